// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
// The state enum is the receiver's frame position; TIMEOUT_CYC_DEFAULT is 2 ms at 50 MHz.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } ps2_state_e;

    localparam logic PS2_STOP_BIT        = 1'b1;
    localparam int   TIMEOUT_CYC_DEFAULT = 100000;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead register FIFO: the head entry is visible on rd_data without a pop.
// Occupancy is tracked in its own counter, so the pointers simply wrap.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_fifo.sv
// PS/2 keyboard receiver that queues scan codes in a FIFO for the HPS to poll.
// Framing, parity and FIFO overflow faults are reported through sticky flags.
module ps2_keycode_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int CODE_W      = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [CODE_W-1:0]             code_out,
    output logic                          code_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BC_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(CODE_W - 1);

    logic              clk_meta, clk_sync, clk_prev;
    logic              dat_meta, dat_sync;
    logic              fall;

    ps2_state_e        state;
    logic [BC_W-1:0]   bit_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [CODE_W-1:0] shift_reg;
    logic              parity_bit;
    logic              push_req;
    logic [CODE_W-1:0] push_code;

    logic              stop_fall;
    logic              stop_ok;
    logic              parity_ok;
    logic              timeout_hit;
    logic              frame_set;
    logic              parity_set;
    logic              overflow_set;
    logic              fifo_empty;
    logic              fifo_full;

    // Two-flop synchronisers plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta <= 1'b0;
            clk_sync <= 1'b0;
            clk_prev <= 1'b0;
            dat_meta <= 1'b0;
            dat_sync <= 1'b0;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    assign fall         = clk_prev && !clk_sync;
    assign stop_fall    = fall && (state == STOP);
    assign stop_ok      = (dat_sync == PS2_STOP_BIT);
    assign parity_ok    = ^{shift_reg, parity_bit};
    assign timeout_hit  = (state != IDLE) && !fall && (to_cnt == TO_LAST);
    assign frame_set    = (stop_fall && !stop_ok) || timeout_hit;
    assign parity_set   = stop_fall && stop_ok && !parity_ok;
    assign overflow_set = push_req && fifo_full && !rd_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            push_req   <= 1'b0;
            push_code  <= '0;
        end else begin
            push_req <= 1'b0;
            if (state == IDLE || fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (timeout_hit) begin
                state   <= IDLE;
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_sync) begin
                            state <= START;
                        end
                    end
                    START: begin
                        shift_reg <= {dat_sync, shift_reg[CODE_W-1:1]};
                        bit_cnt   <= BC_W'(1);
                        state     <= DATA;
                    end
                    DATA: begin
                        shift_reg <= {dat_sync, shift_reg[CODE_W-1:1]};
                        if (bit_cnt == BC_LAST) begin
                            bit_cnt <= '0;
                            state   <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        parity_bit <= dat_sync;
                        state      <= STOP;
                    end
                    STOP: begin
                        push_req  <= stop_ok && parity_ok;
                        push_code <= shift_reg;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A fault raised in the same cycle as clr_err survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overflow   <= (overflow   && !clr_err) || overflow_set;
            parity_err <= (parity_err && !clr_err) || parity_set;
            frame_err  <= (frame_err  && !clr_err) || frame_set;
        end
    end

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_req),
        .pop     (rd_en),
        .wr_data (push_code),
        .rd_data (code_out),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign code_rdy = !fifo_empty;

endmodule

// File: tb/tb_ps2_keycode_fifo.sv
// Bench for ps2_keycode_fifo: directed scenarios plus random traffic, checked
// against a queue-based model of what the keyboard interface should report.
module tb_ps2_keycode_fifo;

    localparam int FIFO_DEPTH  = 16;
    localparam int CODE_W      = 8;
    localparam int TIMEOUT_CYC = 200;
    localparam int HALF        = 20;

    logic                          clk = 1'b0;
    logic                          reset = 1'b1;
    logic                          ps2_clk = 1'b1;
    logic                          ps2_dat = 1'b1;
    logic                          rd_en = 1'b0;
    logic                          clr_err = 1'b0;
    logic [CODE_W-1:0]             code_out;
    logic                          code_rdy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic                          parity_err;
    logic                          frame_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q [$];
    bit         m_ovf, m_par, m_frm;

    always #5 clk = ~clk;

    ps2_keycode_fifo #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .CODE_W      (CODE_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .code_out   (code_out),
        .code_rdy   (code_rdy),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string ctx);
        logic [7:0] head;
        head = (model_q.size() > 0) ? model_q[0] : 8'h00;
        checkOutput({ctx, "/code_out"},   32'(code_out),   32'(head));
        checkOutput({ctx, "/code_rdy"},   32'(code_rdy),   32'(model_q.size() > 0));
        checkOutput({ctx, "/fifo_count"}, 32'(fifo_count), 32'(model_q.size()));
        checkOutput({ctx, "/overflow"},   32'(overflow),   32'(m_ovf));
        checkOutput({ctx, "/parity_err"}, 32'(parity_err), 32'(m_par));
        checkOutput({ctx, "/frame_err"},  32'(frame_err),  32'(m_frm));
    endtask

    // One PS/2 bit: data set while the line clock is high, sampled by the device on the fall.
    task automatic sendBit(input logic b, input bit pulse_rd);
        @(negedge clk);
        ps2_dat = b;
        repeat (HALF - 1) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            rd_en = pulse_rd && (i == 2);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit bad_par,
                                 input bit bad_stop, input bit pop_at_push);
        logic par;
        par = ~^data;
        if (bad_par) par = ~par;
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) sendBit(data[i], 1'b0);
        sendBit(par, 1'b0);
        sendBit(!bad_stop, pop_at_push);
        @(negedge clk);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk);
        if (pop_at_push && model_q.size() > 0) void'(model_q.pop_front());
        if (bad_stop)                          m_frm = 1'b1;
        else if (bad_par)                      m_par = 1'b1;
        else if (model_q.size() == FIFO_DEPTH) m_ovf = 1'b1;
        else                                   model_q.push_back(data);
    endtask

    task automatic popOne();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    task automatic clearErrors();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ovf = 0; m_par = 0; m_frm = 0;
    endtask

    task automatic resetModel();
        model_q.delete();
        m_ovf = 0; m_par = 0; m_frm = 0;
    endtask

    initial begin
        resetModel();
        repeat (4) @(negedge clk);
        checkAll("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkAll("idle");

        // Single frame round trip
        applyStimulus(8'h1C, 0, 0, 0);
        checkAll("single_frame");
        popOne();
        checkAll("single_pop");

        // Fill past capacity, then drain in order
        for (int i = 1; i <= 17; i++) applyStimulus(8'(i), 0, 0, 0);
        checkAll("fill_17");
        for (int i = 0; i < 16; i++) begin
            popOne();
            checkAll("drain");
        end
        popOne();
        checkAll("pop_empty");
        clearErrors();
        checkAll("clr_ovf");

        // Parity fault
        applyStimulus(8'h1C, 1, 0, 0);
        checkAll("parity_bad");
        clearErrors();
        checkAll("parity_clr");

        // Bad stop bit
        applyStimulus(8'h33, 0, 1, 0);
        checkAll("stop_bad");
        clearErrors();

        // Abandoned frame: start bit plus four data bits, then silence
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b0);
        repeat (TIMEOUT_CYC + 20) @(negedge clk);
        m_frm = 1'b1;
        checkAll("timeout");
        applyStimulus(8'h5A, 0, 0, 0);
        checkAll("after_timeout");
        clearErrors();
        popOne();

        // Full FIFO with push and pop landing on the same clock
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'h40 + i), 0, 0, 0);
        checkAll("full_again");
        applyStimulus(8'hA7, 0, 0, 1);
        checkAll("push_pop_full");
        for (int i = 0; i < 16; i++) begin
            popOne();
            checkAll("drain_tail");
        end

        // Reset in the middle of a frame
        applyStimulus(8'h77, 0, 0, 0);
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sendBit(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        resetModel();
        checkAll("mid_reset");
        repeat (5) @(negedge clk);
        applyStimulus(8'h29, 0, 0, 0);
        checkAll("after_reset");

        // Random traffic
        for (int n = 0; n < 30; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 6) begin
                applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
                              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            end else if (op < 9) begin
                popOne();
            end else begin
                clearErrors();
            end
            checkAll("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
